correlator_read_sequencer: RTL

Sequencer for the XOR correlator core's BRAM read path in the stabilization pipeline. On a software start command it latches the current-frame and previous-frame offsets. It then sweeps the row address over one block once per vertical shift candidate and emits latency-aligned row strobes to the XOR/popcount datapath. When all shifts are processed it raises a done pulse and an interrupt event. It sits between the slave register bank (driven by Bus2IP_Clk) and the 16 BRAM read ports feeding the correlator datapath.

---
 rtl/correlator_pkg.sv | 22 ++
 rtl/correlator_read_sequencer_if.sv | 34 +++
 rtl/corr_row_delay.sv | 29 ++
 rtl/correlator_read_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/correlator_pkg.sv
// Shared types and constants for the correlator BRAM read sequencer.
package correlator_pkg;

    localparam int BRAM_ADDR_WIDTH_DEF = 10;
    localparam int CNT_W               = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_ACC = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_FINISH   = 3'd4
    } state_e;

    // Tag carried alongside each issued row until its BRAM data emerges.
    typedef struct packed {
        logic             valid;
        logic             last;
        logic [CNT_W-1:0] idx;
    } row_tag_t;

endpackage

// File: rtl/correlator_read_sequencer_if.sv
// Command/offset/strobe bundle between register bank, sequencer and correlator datapath.
interface correlator_read_sequencer_if
    import correlator_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = BRAM_ADDR_WIDTH_DEF
);
    logic                       start;
    logic                       abort;
    logic [BRAM_ADDR_WIDTH-1:0] curr_base;
    logic [BRAM_ADDR_WIDTH-1:0] prev_base;
    logic [BRAM_ADDR_WIDTH-1:0] row_base;
    logic                       acc_ready;
    logic [BRAM_ADDR_WIDTH-1:0] bram_read_addr;
    logic [BRAM_ADDR_WIDTH-1:0] curr_frame_bram_offset;
    logic [BRAM_ADDR_WIDTH-1:0] prev_frame_bram_offset;
    logic                       row_valid;
    logic                       row_last;
    logic [CNT_W-1:0]           shift_idx;
    logic                       busy;
    logic                       done;
    logic                       intr_event;

    modport master (
        output start, abort, curr_base, prev_base, row_base, acc_ready,
        input  bram_read_addr, curr_frame_bram_offset, prev_frame_bram_offset,
               row_valid, row_last, shift_idx, busy, done, intr_event
    );

    modport slave (
        input  start, abort, curr_base, prev_base, row_base, acc_ready,
        output bram_read_addr, curr_frame_bram_offset, prev_frame_bram_offset,
               row_valid, row_last, shift_idx, busy, done, intr_event
    );
endinterface

// File: rtl/corr_row_delay.sv
// Fixed-depth pipeline aligning row tags with BRAM read data; flush empties every stage.
module corr_row_delay
    import correlator_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     flush_i,
    input  row_tag_t tag_i,
    output row_tag_t tag_o
);
    row_tag_t pipe_q [LATENCY];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[LATENCY-1];
endmodule

// File: rtl/correlator_read_sequencer.sv
// Sweeps one block of rows per vertical shift candidate and emits latency-aligned row strobes.
module correlator_read_sequencer
    import correlator_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = BRAM_ADDR_WIDTH_DEF,
    parameter int ROWS_PER_BLOCK  = 16,
    parameter int NUM_SHIFTS      = 16,
    parameter int BRAM_LATENCY    = 2
) (
    input  logic                      Bus2IP_Clk,
    input  logic                      Bus2IP_Reset,
    correlator_read_sequencer_if.slave bus
);
    localparam int               AW     = BRAM_ADDR_WIDTH;
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(ROWS_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(NUM_SHIFTS - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(BRAM_LATENCY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] r_q, r_d, s_q, s_d, drain_q, drain_d;
    logic [AW-1:0]    addr_q, addr_d, curr_q, curr_d;
    logic [AW-1:0]    prev_base_q, prev_base_d, row_base_q, row_base_d;
    logic [AW-1:0]    prev_off_q, prev_off_d;
    logic             busy_q, done_q, intr_q;
    logic             issue, flush, abort_hit;
    row_tag_t         tag_in, tag_out;

    // FINISH is excluded: the run has already completed and is signalling its own event.
    assign abort_hit = bus.abort &&
                       (state_q inside {ST_WAIT_ACC, ST_ISSUE, ST_DRAIN});

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        s_d         = s_q;
        drain_d     = drain_q;
        addr_d      = addr_q;
        curr_d      = curr_q;
        prev_base_d = prev_base_q;
        row_base_d  = row_base_q;
        prev_off_d  = prev_off_q;
        issue       = 1'b0;
        flush       = 1'b0;

        if (abort_hit) begin
            state_d = ST_IDLE;
            flush   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_d     = ST_WAIT_ACC;
                        curr_d      = bus.curr_base;
                        prev_base_d = bus.prev_base;
                        row_base_d  = bus.row_base;
                        prev_off_d  = bus.prev_base;
                        r_d         = '0;
                        s_d         = '0;
                        drain_d     = '0;
                    end
                end
                ST_WAIT_ACC: begin
                    if (bus.acc_ready) begin
                        state_d = ST_ISSUE;
                        addr_d  = row_base_q;
                    end
                end
                ST_ISSUE: begin
                    issue = 1'b1;
                    if (r_q == R_LAST) begin
                        r_d     = '0;
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        r_d    = r_q + 8'd1;
                        addr_d = addr_q + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == D_LAST) begin
                        s_d     = s_q + 8'd1;
                        drain_d = '0;
                        if (s_q == S_LAST) begin
                            state_d = ST_FINISH;
                        end else begin
                            state_d    = ST_WAIT_ACC;
                            prev_off_d = prev_base_q + AW'(s_d);
                        end
                    end else begin
                        drain_d = drain_q + 8'd1;
                    end
                end
                ST_FINISH: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tag_in = '0;
        if (issue) begin
            tag_in.valid = 1'b1;
            tag_in.last  = (r_q == R_LAST);
            tag_in.idx   = s_q;
        end
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            s_q         <= '0;
            drain_q     <= '0;
            addr_q      <= '0;
            curr_q      <= '0;
            prev_base_q <= '0;
            row_base_q  <= '0;
            prev_off_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            intr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            s_q         <= s_d;
            drain_q     <= drain_d;
            addr_q      <= addr_d;
            curr_q      <= curr_d;
            prev_base_q <= prev_base_d;
            row_base_q  <= row_base_d;
            prev_off_q  <= prev_off_d;
            busy_q      <= (state_d inside {ST_WAIT_ACC, ST_ISSUE, ST_DRAIN});
            done_q      <= (state_d == ST_FINISH);
            intr_q      <= (state_d == ST_FINISH) || abort_hit;
        end
    end

    corr_row_delay #(
        .LATENCY (BRAM_LATENCY)
    ) u_row_delay (
        .clk_i   (Bus2IP_Clk),
        .rst_i   (Bus2IP_Reset),
        .flush_i (flush),
        .tag_i   (tag_in),
        .tag_o   (tag_out)
    );

    assign bus.bram_read_addr         = addr_q;
    assign bus.curr_frame_bram_offset = curr_q;
    assign bus.prev_frame_bram_offset = prev_off_q;
    assign bus.row_valid              = tag_out.valid;
    assign bus.row_last               = tag_out.last;
    assign bus.shift_idx              = tag_out.idx;
    assign bus.busy                   = busy_q;
    assign bus.done                   = done_q;
    assign bus.intr_event             = intr_q;
endmodule
